// File: rtl/dus_img_loader.sv
// rtl/dus_img_loader.sv - frame loader feeding the img memory, then one ap_ctrl_hs run of dus_hls
// Loads NUM_WORDS beats into img, starts the kernel, and muxes the img port to it until ap_done.
module dus_img_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  k_img_ce0,
    input  logic [ADDR_WIDTH-1:0] k_img_address0,
    output logic                  img_ce0,
    output logic                  img_we0,
    output logic [ADDR_WIDTH-1:0] img_address0,
    output logic [DATA_WIDTH-1:0] img_d0,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic                  ap_start_next;
    logic                  frame_done_next;
    logic [15:0]           frame_count_next;
    logic                  accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            ap_start    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            state       <= state_next;
            wr_ptr      <= wr_ptr_next;
            ap_start    <= ap_start_next;
            frame_done  <= frame_done_next;
            frame_count <= frame_count_next;
        end
    end

    always_comb begin
        state_next       = state;
        wr_ptr_next      = wr_ptr;
        frame_done_next  = 1'b0;
        frame_count_next = frame_count;
        in_ready         = 1'b0;
        accept           = 1'b0;
        img_ce0          = 1'b0;
        img_we0          = 1'b0;
        img_address0     = wr_ptr[ADDR_WIDTH-1:0];
        img_d0           = in_data;

        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                img_ce0  = accept;
                img_we0  = accept;
                if (accept) begin
                    if (wr_ptr == LAST_PTR) begin
                        wr_ptr_next = '0;
                        state_next  = ST_START;
                    end else begin
                        wr_ptr_next = wr_ptr + 1'b1;
                    end
                end
            end
            ST_START: begin
                img_ce0      = k_img_ce0;
                img_address0 = k_img_address0;
                img_d0       = '0;
                // A kernel that finishes in its start-handshake cycle completes the frame directly.
                if (ap_ready) begin
                    if (ap_done) begin
                        state_next       = ST_LOAD;
                        frame_done_next  = 1'b1;
                        frame_count_next = frame_count + 16'd1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                img_ce0      = k_img_ce0;
                img_address0 = k_img_address0;
                img_d0       = '0;
                if (ap_done) begin
                    state_next       = ST_LOAD;
                    frame_done_next  = 1'b1;
                    frame_count_next = frame_count + 16'd1;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        ap_start_next = (state_next == ST_START);
    end

endmodule

// File: tb/tb_dus_img_loader.sv
// tb/tb_dus_img_loader.sv - randomized bench for dus_img_loader against a frame-level reference model
module tb_dus_img_loader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          k_img_ce0;
    logic [AW-1:0] k_img_address0;
    logic          img_ce0;
    logic          img_we0;
    logic [AW-1:0] img_address0;
    logic [DW-1:0] img_d0;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          frame_done;
    logic [15:0]   frame_count;

    int errors = 0;
    int checks = 0;

    // Reference model: beats loaded so far, start request outstanding, kernel running.
    int m_beats;
    bit m_start_req;
    bit m_running;
    bit m_fd;
    int m_cnt;
    int m_frames;

    always #5 clk = ~clk;

    dus_img_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .k_img_ce0(k_img_ce0), .k_img_address0(k_img_address0),
        .img_ce0(img_ce0), .img_we0(img_we0), .img_address0(img_address0), .img_d0(img_d0),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_beats = 0; m_start_req = 0; m_running = 0; m_fd = 0; m_cnt = 0;
    endtask

    task automatic complete_frame();
        m_fd = 1;
        m_cnt = (m_cnt + 1) % 65536;
        m_frames++;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit kce,
                        input logic [AW-1:0] kaddr, input bit rdy, input bit done);
        bit loading;
        bit acc;
        in_valid = v; in_data = d; k_img_ce0 = kce; k_img_address0 = kaddr;
        ap_ready = rdy; ap_done = done;
        loading = !m_start_req && !m_running;
        acc = loading && v;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(loading));
        chk("img_we0", 32'(img_we0), 32'(acc));
        chk("img_ce0", 32'(img_ce0), loading ? 32'(acc) : 32'(kce));
        chk("img_address0", 32'(img_address0), loading ? 32'(m_beats) : 32'(kaddr));
        chk("img_d0", img_d0, loading ? d : 32'd0);
        chk("ap_start", 32'(ap_start), 32'(m_start_req));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("frame_count", 32'(frame_count), 32'(m_cnt));
        @(posedge clk);
        m_fd = 0;
        if (acc) begin
            m_beats++;
            if (m_beats == NW) begin
                m_beats = 0;
                m_start_req = 1;
            end
        end else if (m_start_req) begin
            if (rdy) begin
                m_start_req = 0;
                if (done) complete_frame();
                else m_running = 1;
            end
        end else if (m_running && done) begin
            m_running = 0;
            complete_frame();
        end
        #1;
    endtask

    // Random inputs everywhere; ap_done is never raised alongside an unanswered start.
    task automatic rand_step(input int valid_pct);
        bit v, rdy, done;
        v = ($urandom_range(99) < valid_pct);
        rdy = ($urandom_range(99) < 30);
        done = ($urandom_range(99) < 20);
        if (m_start_req && !rdy) done = 0;
        step(v, $urandom, 1'($urandom), AW'($urandom), rdy, done);
    endtask

    task automatic rand_frame(input int valid_pct);
        int start_frames;
        int n;
        start_frames = m_frames;
        n = 0;
        while (m_frames == start_frames && n < 20000) begin
            rand_step(valid_pct);
            n++;
        end
        chk("rand_frame_timeout", 32'(m_frames == start_frames), 32'd0);
    endtask

    task automatic async_reset();
        in_valid = 0; ap_ready = 0; ap_done = 0; k_img_ce0 = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ap_start", 32'(ap_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = '0; k_img_ce0 = 0; k_img_address0 = '0;
        ap_ready = 0; ap_done = 0;
        m_frames = 0;
        model_reset();
        #3;
        chk("init_ap_start", 32'(ap_start), 32'd0);
        chk("init_frame_count", 32'(frame_count), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;

        // Back-to-back frame with data = index, then ap_ready held low for 5 cycles.
        for (int i = 0; i < NW; i++) step(1, DW'(i), 0, '0, 0, 0);
        chk("t1_start_pending", 32'(m_start_req), 32'd1);
        for (int i = 0; i < 5; i++) step(0, '0, 0, '0, 0, 0);
        step(0, '0, 0, '0, 1, 0);
        // Kernel reads the top address while running, then finishes.
        for (int i = 0; i < 3; i++) step(0, '0, 1, 10'h3FF, 0, 0);
        step(0, '0, 1, 10'h3FF, 0, 1);
        step(0, '0, 0, '0, 0, 0);
        chk("t4_frame_count", 32'(m_cnt), 32'd1);
        step(0, '0, 0, '0, 0, 0);

        // Gapped frame, then ready and done together.
        for (int i = 0; i < 4000 && !m_start_req; i++) step($urandom_range(1), $urandom, 0, '0, 0, 0);
        step(0, '0, 0, '0, 1, 1);
        step(1, $urandom, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        chk("t5_frame_count", 32'(m_cnt), 32'd2);

        // Fully randomized frames, including ignored ap_done while loading.
        rand_frame(50);
        rand_frame(50);
        rand_frame(90);

        // Reset mid-frame after 300 beats; next frame restarts at address 0.
        for (int i = 0; i < 300; i++) step(1, $urandom, 0, '0, 0, 0);
        async_reset();
        rand_frame(70);

        // Reset while ap_start is held.
        for (int i = 0; i < NW; i++) step(1, $urandom, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        async_reset();
        rand_frame(60);
        chk("final_frame_count", 32'(m_cnt), 32'd1);
        step(0, '0, 0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
